// File: rtl/max7219_seq.sv
// MAX7219-class display command sequencer: autonomous power-up init, then digit refresh on
// request, driving the SPI pins through its own divider/shifter/LOAD framing engine.
module max7219_seq #(
   parameter int         CLK_DIV    = 4,
   parameter int         NUM_DIGITS = 8,
   parameter logic [7:0] DECODE     = 8'h00,
   parameter logic [3:0] INTENSITY  = 4'h7
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [NUM_DIGITS*8-1:0]   digits,
   output logic                      sclk,
   output logic                      sdo,
   output logic                      cs_n,
   output logic                      busy,
   output logic                      ready,
   output logic                      done
);

   localparam int               DIV_W     = $clog2(CLK_DIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]       HALF_LAST = 6'd33;
   localparam logic [3:0]       INIT_LAST = 4'd4;
   localparam logic [3:0]       DIG_LAST  = 4'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REFRESH, ST_FINISH} state_e;

   state_e                  state_q, state_d;
   logic                    active_q, active_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [5:0]              half_q, half_d;
   logic [3:0]              idx_q, idx_d;
   logic [NUM_DIGITS*8-1:0] dig_q, dig_d;
   logic                    sclk_q, sclk_d;
   logic                    sdo_q, sdo_d;
   logic                    cs_n_q, cs_n_d;
   logic                    busy_q, busy_d;
   logic                    ready_q, ready_d;
   logic                    done_q, done_d;

   logic                    half_end_s;
   logic                    frame_end_s;
   logic                    shifting_s;
   logic [3:0]              bit_sel_s;
   logic [7:0]              digit_s;
   logic [15:0]             frame_s;

   function automatic logic [15:0] init_frame(input logic [3:0] i);
      case (i)
         4'd0:    init_frame = 16'h0C01;
         4'd1:    init_frame = {8'h09, DECODE};
         4'd2:    init_frame = {8'h0A, 4'h0, INTENSITY};
         4'd3:    init_frame = {8'h0B, 8'(NUM_DIGITS - 1)};
         4'd4:    init_frame = 16'h0F00;
         default: init_frame = 16'h0000;
      endcase
   endfunction

   // Frame engine: a frame is 34 half-periods of CLK_DIV cycles; 0..31 shift, 32..33 are the gap.
   always_comb begin
      half_end_s  = (div_q == DIV_LAST);
      frame_end_s = active_q && half_end_s && (half_q == HALF_LAST);
      state_d     = state_q;
      active_d    = active_q;
      idx_d       = idx_q;
      dig_d       = dig_q;
      div_d       = '0;
      half_d      = '0;
      if (active_q && half_end_s) begin
         half_d = half_q + 6'd1;
      end else if (active_q) begin
         div_d  = div_q + DIV_W'(1);
         half_d = half_q;
      end else begin
         half_d = '0;
      end

      case (state_q)
         ST_INIT: begin
            if (!active_q) begin
               active_d = 1'b1;
            end else if (frame_end_s) begin
               half_d = '0;
               if (idx_q == INIT_LAST) begin
                  state_d  = ST_IDLE;
                  active_d = 1'b0;
                  idx_d    = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_REFRESH;
               active_d = 1'b1;
               idx_d    = '0;
               dig_d    = digits;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REFRESH: begin
            if (frame_end_s) begin
               half_d = '0;
               if (idx_q == DIG_LAST) begin
                  state_d  = ST_FINISH;
                  active_d = 1'b0;
                  idx_d    = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default: begin
            state_d  = ST_INIT;
            active_d = 1'b0;
            idx_d    = '0;
         end
      endcase
   end

   // Pin values are derived from the next engine state so every output comes straight off a flop.
   always_comb begin
      digit_s = 8'h00;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         digit_s = (idx_d == 4'(k)) ? dig_d[8*k +: 8] : digit_s;
      end
      if (state_d == ST_REFRESH) begin
         frame_s = {4'h0, idx_d + 4'd1, digit_s};
      end else begin
         frame_s = init_frame(idx_d);
      end
      shifting_s = active_d && !half_d[5];
      bit_sel_s  = 4'd15 - half_d[4:1];
      cs_n_d     = ~shifting_s;
      sclk_d     = shifting_s & half_d[0];
      sdo_d      = shifting_s & frame_s[bit_sel_s];
      busy_d     = (state_d != ST_IDLE);
      ready_d    = (state_d == ST_IDLE);
      done_d     = (state_d == ST_FINISH);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_INIT;
         active_q <= 1'b0;
         div_q    <= '0;
         half_q   <= '0;
         idx_q    <= '0;
         dig_q    <= '0;
         sclk_q   <= 1'b0;
         sdo_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         busy_q   <= 1'b1;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         div_q    <= div_d;
         half_q   <= half_d;
         idx_q    <= idx_d;
         dig_q    <= dig_d;
         sclk_q   <= sclk_d;
         sdo_q    <= sdo_d;
         cs_n_q   <= cs_n_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   assign sclk  = sclk_q;
   assign sdo   = sdo_q;
   assign cs_n  = cs_n_q;
   assign busy  = busy_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: doc/max7219_seq.md
Name: max7219_seq

Overview:
- Parametrised SPI command sequencer for MAX7219-class 7-segment display drivers.
- After reset it autonomously sends a configurable power-up init sequence of 16-bit address/data frames.
- It then refreshes NUM_DIGITS digit registers from a parallel input on each start request, with a start/busy/done handshake.
- Contains its own bit engine: clock divider, shift register and LOAD/CS framing. It sits between the display application logic and the display pins.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period (>=1).
- NUM_DIGITS, 8, digits refreshed per start (1..8); scan-limit register is programmed to NUM_DIGITS-1.
- DECODE, 8'h00, value written to decode-mode register (0x09).
- INTENSITY, 4'h7, value written to intensity register (0x0A), zero-extended to 8 bits.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a digit refresh; sampled when ready=1
- digits  in  NUM_DIGITS*8  digit bytes; byte k (bits 8k+7:8k) goes to MAX7219 address k+1
- sclk  out  1  SPI clock, mode 0, idles low
- sdo  out  1  serial data, MSB first
- cs_n  out  1  frame enable/LOAD, active low; device latches on rising edge
- busy  out  1  high while any frame is in progress or pending
- ready  out  1  high when init is complete and the block is idle
- done  out  1  one-cycle pulse at the end of each refresh

Behaviour:
- Reset (async assert, sync release): sclk=0, sdo=0, cs_n=1, busy=1, ready=0, done=0, state=INIT, frame index=0. Asserting reset mid-frame forces these values immediately. Init restarts from frame 0 on release.
- Frame format: {8'h0, addr[7:0]... } — more precisely, bits 15:12=0, 11:8=address, 7:0=data.
- Init sequence, fixed order:
  - 0x0C01 (shutdown off)
  - {0x09, DECODE}
  - {0x0A, INTENSITY}
  - {0x0B, NUM_DIGITS-1}
  - 0x0F00 (display test off)
- Frame timing, with cycle 0 = cs_n falling edge:
  - Cycle 0: sdo=bit15.
  - Rising edge of sclk at cycle (2i+1)*CLK_DIV for bit 15-i; falling edge at (2i+2)*CLK_DIV.
  - sdo updates to the next bit on the same cycle as the falling edge.
  - cs_n rises at cycle 32*CLK_DIV, with sclk already low.
  - cs_n is held high for a gap of 2*CLK_DIV cycles before the next frame may start.
  - Frame period = 34*CLK_DIV cycles.
  - sdo returns to 0 while cs_n=1.
- States:
  - INIT: send 5 init frames back to back.
  - IDLE: busy=0, ready=1.
  - REFRESH: send NUM_DIGITS frames, addresses 1..NUM_DIGITS ascending.
  - FINISH: one cycle; done=1; then go to IDLE.
- Transitions:
  - INIT → IDLE at the end of the gap after the last init frame. No done pulse for init.
  - IDLE with start=1 → REFRESH. The digits bus is latched in full on that cycle; later changes to digits do not affect the refresh in progress.
  - The first cs_n fall occurs on the cycle after start is accepted.
  - REFRESH → FINISH at the end of the gap after the last digit frame.
- start while busy=1 (INIT, REFRESH or FINISH) is ignored, not queued.
- start held high continuously: a new refresh begins on the first IDLE cycle after FINISH. This gives 1 idle cycle between refreshes.
- ready = ~busy once init is complete; ready and busy are never both 1.
- The divider counter is compared against CLK_DIV-1 using width clog2(CLK_DIV)+1. With CLK_DIV=1, sclk toggles every cycle.

Test Plan:
- Reset release, CLK_DIV=2, NUM_DIGITS=4:
  - 5 frames decoded on sclk rising edges: 0x0C01, 0x0900, 0x0A07, 0x0B03, 0x0F00.
  - Each frame has cs_n low for exactly 64 cycles and high for 4 cycles between frames.
  - ready rises at cycle 340 after reset release.
- start with digits=32'h0F0E0D0C:
  - Frames 0x010C, 0x020D, 0x030E, 0x040F.
  - done pulses once, 1 cycle after the last gap.
  - busy is high for 272 cycles plus the FINISH cycle.
- Change digits to 32'hFFFFFFFF one cycle after start is accepted → transmitted frames are still the latched 0x010C..0x040F.
- Pulse start during INIT and again mid-refresh → no extra frames; exactly one done per accepted start.
- Assert rst_n low at bit 7 of the third refresh frame:
  - cs_n=1, sclk=0, sdo=0 within the same cycle.
  - After release, the full init sequence repeats from 0x0C01.
- CLK_DIV=1, NUM_DIGITS=1, start held high:
  - Back-to-back refreshes, each a single frame 0x01xx with period 34 cycles.
  - 1 idle cycle between each done pulse and the next cs_n fall.
